// File: rtl/wb_victim_buffer_if.sv
// Bundle of wb_victim_buffer signals: controller victim push, line-fill read
// request, and the single memory port owned by the buffer.
interface wb_victim_buffer_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LINE_W = 64
);
    // Controller push side
    logic              wb_push;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic              wb_full;
    logic              wb_empty;
    // Controller line-fill side
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LINE_W-1:0] rd_data;
    logic              rd_done;
    // Memory port
    logic [ADDR_W-1:0] m_addr;
    logic              m_re;
    logic              m_we;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_rdy;

    // View of the victim buffer itself
    modport slave (
        input  wb_push, wb_addr, wb_data, rd_req, rd_addr, m_rdata, m_rdy,
        output wb_full, wb_empty, rd_data, rd_done, m_addr, m_re, m_we, m_wdata
    );

    // View of the surrounding system (controller plus memory)
    modport master (
        output wb_push, wb_addr, wb_data, rd_req, rd_addr, m_rdata, m_rdy,
        input  wb_full, wb_empty, rd_data, rd_done, m_addr, m_re, m_we, m_wdata
    );
endinterface

// File: rtl/wb_victim_buffer.sv
// Write-back victim buffer: holds evicted dirty lines in a small circular FIFO,
// drains them to memory in the background, and serves line-fill reads either
// from a buffered line (forward) or from memory.
module wb_victim_buffer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LINE_W = 64
) (
    input logic               clk,
    input logic               rst_n,
    wb_victim_buffer_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFwd, StRead, StWrite} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [LINE_W-1:0] data_q  [DEPTH];
    logic              full_q, empty_q;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_done_q, rd_done_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_re_q, m_re_d, m_we_q, m_we_d;
    logic [LINE_W-1:0] m_wdata_q, m_wdata_d;

    logic              rd_hit, cl_hit;
    logic [PTR_W-1:0]  rd_idx, cl_idx, scan_idx;
    logic              req, pop, push_ok, coalesce, append;

    // Scan oldest to youngest so the last match found is the youngest entry.
    always_comb begin
        rd_hit   = 1'b0;
        rd_idx   = '0;
        cl_hit   = 1'b0;
        cl_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (valid_q[scan_idx] && addr_q[scan_idx] == bus.rd_addr) begin
                rd_hit = 1'b1;
                rd_idx = scan_idx;
            end
            // The head being written to memory must not change under the write.
            if (valid_q[scan_idx] && addr_q[scan_idx] == bus.wb_addr &&
                !(state_q == StWrite && scan_idx == head_q)) begin
                cl_hit = 1'b1;
                cl_idx = scan_idx;
            end
        end
    end

    // Push/pop decode and pointer/count next state.
    always_comb begin
        // rd_req is still high during the rd_done cycle; that is not a new request.
        req      = bus.rd_req && !rd_done_q;
        pop      = (state_q == StWrite) && bus.m_rdy;
        push_ok  = bus.wb_push && (!full_q || pop);
        coalesce = push_ok && cl_hit;
        append   = push_ok && !cl_hit;
        head_d   = head_q + PTR_W'(pop);
        tail_d   = tail_q + PTR_W'(append);
        count_d  = count_q + CNT_W'(append) - CNT_W'(pop);
    end

    // Control FSM: next state and registered memory/read outputs.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rd_done_d = 1'b0;
        m_addr_d  = m_addr_q;
        m_re_d    = m_re_q;
        m_we_d    = m_we_q;
        m_wdata_d = m_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req && rd_hit) begin
                    state_d   = StFwd;
                    rd_data_d = data_q[rd_idx];
                end else if (count_q == CNT_W'(DEPTH) || (!req && count_q != '0)) begin
                    state_d  = StWrite;
                    m_we_d   = 1'b1;
                    m_addr_d = addr_q[head_q];
                    // A same-cycle coalesce into the head must reach memory.
                    m_wdata_d = (coalesce && cl_idx == head_q) ? bus.wb_data : data_q[head_q];
                end else if (req) begin
                    state_d  = StRead;
                    m_re_d   = 1'b1;
                    m_addr_d = bus.rd_addr;
                end
            end
            StFwd: begin
                rd_done_d = 1'b1;
                state_d   = StIdle;
            end
            StRead: begin
                if (bus.m_rdy) begin
                    rd_data_d = bus.m_rdata;
                    rd_done_d = 1'b1;
                    m_re_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            StWrite: begin
                if (bus.m_rdy) begin
                    m_we_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
            rd_done_q <= 1'b0;
            m_addr_q  <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_q    <= (count_d == CNT_W'(DEPTH));
            empty_q   <= (count_d == '0);
            rd_data_q <= rd_data_d;
            rd_done_q <= rd_done_d;
            m_addr_q  <= m_addr_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Entry storage; an append into the slot freed by the same-cycle pop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (coalesce) begin
                data_q[cl_idx] <= bus.wb_data;
            end
            if (append) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= bus.wb_addr;
                data_q[tail_q]  <= bus.wb_data;
            end
        end
    end

    assign bus.wb_full  = full_q;
    assign bus.wb_empty = empty_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_done  = rd_done_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_re     = m_re_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_wdata  = m_wdata_q;
endmodule
